// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-side handshake bundle for the unified memory arbiter.
// The master view belongs to the arbiter and the slave view to the pipeline/memory.
interface unified_mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// freezes the pipeline while an access is outstanding and aborts hung accesses.
module unified_mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.master bus,
  output logic                 pipe_stall,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {StIdle, StData, StFetch, StResp} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e        stateQ, stateD;
  logic          memReqQ, memReqD;
  logic          memWeQ, memWeD;
  logic [AW-1:0] memAddrQ, memAddrD;
  logic [DW-1:0] memWdataQ, memWdataD;
  logic [DW-1:0] ifRdataQ, ifRdataD;
  logic [DW-1:0] dmRdataQ, dmRdataD;
  logic          ifAckQ, ifAckD;
  logic          dmAckQ, dmAckD;
  logic          errQ, errD;
  logic [7:0]    cntQ, cntD;
  logic [7:0]    cntInc;

  always_comb begin
    stateD    = stateQ;
    memReqD   = memReqQ;
    memWeD    = memWeQ;
    memAddrD  = memAddrQ;
    memWdataD = memWdataQ;
    ifRdataD  = ifRdataQ;
    dmRdataD  = dmRdataQ;
    ifAckD    = 1'b0;
    dmAckD    = 1'b0;
    errD      = errQ;
    cntD      = cntQ;
    cntInc    = cntQ + 8'd1;

    unique case (stateQ)
      StIdle: begin
        // Data wins: it belongs to the older instruction in the pipeline.
        if (bus.dm_req) begin
          stateD    = StData;
          memReqD   = 1'b1;
          memWeD    = bus.dm_we;
          memAddrD  = bus.dm_addr;
          memWdataD = bus.dm_wdata;
          cntD      = 8'd0;
        end else if (bus.if_req) begin
          stateD   = StFetch;
          memReqD  = 1'b1;
          memWeD   = 1'b0;
          memAddrD = bus.if_addr;
          cntD     = 8'd0;
        end
      end
      StData, StFetch: begin
        if (bus.mem_ready) begin
          memReqD = 1'b0;
          memWeD  = 1'b0;
          stateD  = StResp;
          if (stateQ == StData) begin
            dmAckD = 1'b1;
            if (!memWeQ) dmRdataD = bus.mem_rdata;
          end else begin
            ifAckD   = 1'b1;
            ifRdataD = bus.mem_rdata;
          end
        end else if (cntInc == TimeoutCnt) begin
          // Hung memory: flag it and still complete the access with zero data.
          memReqD = 1'b0;
          memWeD  = 1'b0;
          errD    = 1'b1;
          cntD    = cntInc;
          stateD  = StResp;
          if (stateQ == StData) begin
            dmAckD   = 1'b1;
            dmRdataD = '0;
          end else begin
            ifAckD   = 1'b1;
            ifRdataD = '0;
          end
        end else begin
          cntD = cntInc;
        end
      end
      StResp: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= StIdle;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      ifAckQ    <= 1'b0;
      dmAckQ    <= 1'b0;
      errQ      <= 1'b0;
      cntQ      <= 8'd0;
    end else begin
      stateQ    <= stateD;
      memReqQ   <= memReqD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memWdataQ <= memWdataD;
      ifRdataQ  <= ifRdataD;
      dmRdataQ  <= dmRdataD;
      ifAckQ    <= ifAckD;
      dmAckQ    <= dmAckD;
      errQ      <= errD;
      cntQ      <= cntD;
    end
  end

  assign bus.mem_req   = memReqQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_wdata = memWdataQ;
  assign bus.if_ack    = ifAckQ;
  assign bus.if_rdata  = ifRdataQ;
  assign bus.dm_ack    = dmAckQ;
  assign bus.dm_rdata  = dmRdataQ;
  assign err_timeout   = errQ;

  // Low in the ack cycle so every stage register advances exactly once.
  assign pipe_stall = (bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a latency-programmable memory model plus
// scoreboard queues of expected memory transactions and requester responses.
module tb_unified_mem_arbiter;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 16;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pipe_stall;
  logic err_timeout;

  unified_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  unified_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pipe_stall (pipe_stall),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          cycles;  // expected mem_req high time, -1 = not checked
  } mem_exp_t;

  typedef struct {
    logic        isData;
    logic [15:0] data;
  } resp_exp_t;

  mem_exp_t  memQ[$];
  resp_exp_t respQ[$];

  int nAssert = 0;
  int nFail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushMem(input logic [15:0] a, input logic we, input logic [15:0] wd,
                         input int cyc);
    mem_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.cycles = cyc;
    memQ.push_back(e);
  endtask

  task automatic pushResp(input logic isData, input logic [15:0] d);
    resp_exp_t r;
    r.isData = isData; r.data = d;
    respQ.push_back(r);
  endtask

  // Memory model: mem_ready pulses once mem_req has been high for lat cycles.
  logic [15:0] memArr [0:255];
  int          lat    = 1;
  int          memCnt = 0;

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'h0000;
    memArr[2]  = 16'h1234;
    memArr[8]  = 16'h4321;
    memArr[0]  = 16'h00FF;
    memArr[16] = 16'h7777;
    memArr[24] = 16'hA5A5;
    memArr[32] = 16'h5A5A;
    memArr[40] = 16'h9999;
    memArr[48] = 16'hC0DE;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && bus.mem_req) begin
        if (memCnt == lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) memArr[bus.mem_addr[8:1]] = bus.mem_wdata;
          else bus.mem_rdata = memArr[bus.mem_addr[8:1]];
        end else begin
          bus.mem_ready = 1'b0;
        end
        memCnt++;
      end else begin
        bus.mem_ready = 1'b0;
        memCnt = 0;
      end
    end
  end

  // Monitor: pops scoreboard entries as the DUT issues requests and acks.
  logic      monPrevReq = 1'b0;
  logic      monPrevAck = 1'b0;
  logic      monHave    = 1'b0;
  int        monHi      = 0;
  mem_exp_t  monCur;
  resp_exp_t monResp;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        monPrevReq = 1'b0;
        monPrevAck = 1'b0;
        monHave    = 1'b0;
        continue;
      end
      if (bus.mem_req && !monPrevReq) begin
        check("mem_pending", 32'(memQ.size() > 0), 32'd1);
        if (memQ.size() > 0) begin
          monCur  = memQ.pop_front();
          monHave = 1'b1;
          monHi   = 0;
        end
      end
      if (bus.mem_req && monHave) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(monCur.addr));
        check("mem_we", 32'(bus.mem_we), 32'(monCur.we));
        if (monCur.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(monCur.wdata));
        monHi++;
      end
      if (!bus.mem_req && monPrevReq && monHave) begin
        if (monCur.cycles >= 0) check("mem_req_cycles", 32'(monHi), 32'(monCur.cycles));
        monHave = 1'b0;
      end
      if (bus.if_ack || bus.dm_ack) begin
        check("ack_exclusive", 32'(bus.if_ack & bus.dm_ack), 32'd0);
        check("ack_single_pulse", 32'(monPrevAck), 32'd0);
        check("ack_no_mem_req", 32'(bus.mem_req), 32'd0);
        check("resp_pending", 32'(respQ.size() > 0), 32'd1);
        if (respQ.size() > 0) begin
          monResp = respQ.pop_front();
          check("resp_port", 32'(bus.dm_ack), 32'(monResp.isData));
          check("resp_data", monResp.isData ? 32'(bus.dm_rdata) : 32'(bus.if_rdata),
                32'(monResp.data));
        end
      end
      monPrevReq = bus.mem_req;
      monPrevAck = bus.if_ack | bus.dm_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  logic ifDrop = 1'b0;
  logic dmDrop = 1'b0;

  // Requesters drop req on the edge that ends their ack cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (ifDrop) begin bus.if_req = 1'b0; ifDrop = 1'b0; end
    if (dmDrop) begin bus.dm_req = 1'b0; dmDrop = 1'b0; end
    if (bus.if_ack) ifDrop = 1'b1;
    if (bus.dm_ack) dmDrop = 1'b1;
    #1;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    while ((bus.if_req || bus.dm_req || ifDrop || dmDrop) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_in_budget"}, 32'(n < budget), 32'd1);
    if (n >= budget) begin
      bus.if_req = 1'b0; bus.dm_req = 1'b0; ifDrop = 1'b0; dmDrop = 1'b0;
    end
    step();
  endtask

  initial begin
    bus.if_req   = 1'b0;
    bus.if_addr  = 16'h0000;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 16'h0000;
    bus.dm_wdata = 16'h0000;
    #12;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_if_ack", 32'(bus.if_ack), 32'd0);
    check("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
    check("rst_if_rdata", 32'(bus.if_rdata), 32'd0);
    check("rst_dm_rdata", 32'(bus.dm_rdata), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Fetch with one cycle of memory latency: ack three cycles after the request.
    lat = 1;
    pushMem(16'h0004, 1'b0, 16'h0000, 2);
    pushResp(1'b0, 16'h1234);
    bus.if_addr = 16'h0004;
    bus.if_req  = 1'b1;
    #1;
    check("fetch_stall_c0", 32'(pipe_stall), 32'd1);
    step();
    check("fetch_mem_req_c1", 32'(bus.mem_req), 32'd1);
    check("fetch_stall_c1", 32'(pipe_stall), 32'd1);
    step();
    check("fetch_ack_c2", 32'(bus.if_ack), 32'd0);
    check("fetch_stall_c2", 32'(pipe_stall), 32'd1);
    step();
    check("fetch_ack_c3", 32'(bus.if_ack), 32'd1);
    check("fetch_stall_c3", 32'(pipe_stall), 32'd0);
    check("fetch_rdata", 32'(bus.if_rdata), 32'h1234);
    waitDone(10, "fetch");

    // Simultaneous store and fetch: store first, dm_rdata unchanged by the store.
    pushMem(16'h0100, 1'b1, 16'hBEEF, 2);
    pushResp(1'b1, 16'h0000);
    pushMem(16'h0010, 1'b0, 16'h0000, 2);
    pushResp(1'b0, 16'h4321);
    bus.if_addr  = 16'h0010;
    bus.if_req   = 1'b1;
    bus.dm_addr  = 16'h0100;
    bus.dm_we    = 1'b1;
    bus.dm_wdata = 16'hBEEF;
    bus.dm_req   = 1'b1;
    step();
    // Inputs change after the grant edge; the captured store must not follow them.
    bus.dm_wdata = 16'h1111;
    bus.dm_addr  = 16'h0102;
    waitDone(30, "simul");
    check("simul_store_mem", 32'(memArr[8'h80]), 32'hBEEF);

    // Load with four cycles of memory latency.
    lat = 4;
    pushMem(16'h0200, 1'b0, 16'h0000, 5);
    pushResp(1'b1, 16'h00FF);
    bus.dm_addr = 16'h0200;
    bus.dm_we   = 1'b0;
    bus.dm_req  = 1'b1;
    waitDone(30, "load4");

    // Memory never answers: abort after TIMEOUT wait cycles with zero data.
    lat = -1;
    check("pre_timeout_err", 32'(err_timeout), 32'd0);
    pushMem(16'h0020, 1'b0, 16'h0000, TIMEOUT);
    pushResp(1'b1, 16'h0000);
    bus.dm_addr = 16'h0020;
    bus.dm_req  = 1'b1;
    waitDone(40, "timeout");
    check("timeout_err", 32'(err_timeout), 32'd1);
    lat = 1;
    pushMem(16'h0030, 1'b0, 16'h0000, 2);
    pushResp(1'b0, 16'hA5A5);
    bus.if_addr = 16'h0030;
    bus.if_req  = 1'b1;
    waitDone(20, "after_timeout");
    check("timeout_err_sticky", 32'(err_timeout), 32'd1);

    // Reset during a data wait; the held fetch is serviced after release.
    lat = -1;
    pushMem(16'h0050, 1'b0, 16'h0000, -1);
    pushResp(1'b1, 16'h0000);
    bus.dm_addr = 16'h0050;
    bus.dm_req  = 1'b1;
    bus.if_addr = 16'h0060;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
    check("midrst_dm_ack", 32'(bus.dm_ack), 32'd0);
    check("midrst_if_ack", 32'(bus.if_ack), 32'd0);
    check("midrst_err", 32'(err_timeout), 32'd0);
    void'(respQ.pop_back());
    bus.dm_req = 1'b0;
    dmDrop     = 1'b0;
    step();
    check("inrst_dm_ack", 32'(bus.dm_ack), 32'd0);
    step();
    lat = 2;
    pushMem(16'h0060, 1'b0, 16'h0000, 3);
    pushResp(1'b0, 16'hC0DE);
    rst_n = 1'b1;
    waitDone(20, "after_reset");

    // Ready in the last allowed wait cycle completes normally.
    lat = TIMEOUT - 1;
    pushMem(16'h0040, 1'b0, 16'h0000, TIMEOUT);
    pushResp(1'b1, 16'h5A5A);
    bus.dm_addr = 16'h0040;
    bus.dm_req  = 1'b1;
    waitDone(40, "boundary");
    check("boundary_err", 32'(err_timeout), 32'd0);

    step();
    check("memq_drained", 32'(memQ.size()), 32'd0);
    check("respq_drained", 32'(respQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency 16-bit memory between the instruction-fetch port (IF stage) and the data port (MM stage, lw/sw) of the 5-stage pipeline.
- Sequences one transaction at a time with a req/ack handshake on each requester side and a req/ready handshake on the memory side.
- Generates the pipeline freeze signal that holds the PC and all stage registers while any access is outstanding.
- Watchdog on the memory handshake raises a sticky error and completes the hung access.

Parameters:
- AW, 16, address width (byte address; PC steps by 2)
- DW, 16, data width
- TIMEOUT, 15, max cycles mem_req may wait for mem_ready before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address (pcOutput)
- if_ack  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched instruction
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1=store (sw), 0=load (lw)
- dm_addr  in  AW  data address (ALU result)
- dm_wdata  in  DW  store data
- dm_ack  out  1  one-cycle pulse: access done, dm_rdata valid for loads
- dm_rdata  out  DW  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle per access
- pipe_stall  out  1  freeze PC and pipeline registers
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, if_ack, dm_ack, err_timeout=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; wait counter=0.
- FSM states: IDLE, DATA, FETCH, RESP.
- IDLE: if dm_req -> DATA; else if if_req -> FETCH; else stay. Data has fixed priority, because it belongs to the older instruction.
- On the grant edge, register mem_req=1, mem_addr, mem_we (dm_we for DATA, 0 for FETCH), and mem_wdata. mem_req therefore rises the cycle after the request is first seen in IDLE.
- DATA/FETCH: hold mem_* stable until mem_ready=1. On that edge:
  - mem_req drops to 0.
  - mem_rdata is captured into dm_rdata (DATA load) or if_rdata (FETCH). For a store, dm_rdata holds its previous value.
  - The matching ack is set to 1 and the FSM moves to RESP.
- RESP: ack high exactly one cycle; the requester drops req on the edge ending this cycle. Then go to IDLE. Minimum request-to-ack latency = 2 + memory latency cycles. One bubble cycle separates back-to-back transactions.
- mem_ready in IDLE/RESP is ignored.
- Requester inputs (addr, we, wdata) are sampled only on the grant edge. Later changes during the access have no effect.
- Watchdog:
  - The counter clears on grant and increments every DATA/FETCH cycle without mem_ready.
  - When it reaches TIMEOUT: err_timeout=1 (sticky until reset), mem_req drops, the response data register loads 0, the ack pulses via RESP, and the FSM returns to IDLE.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no error.
- pipe_stall (combinational) = (if_req & ~if_ack) | (dm_req & ~dm_ack). It is 1 in the grant cycle and through all wait cycles, and 0 in the ack cycle so the pipeline advances exactly once.
- A request deasserted before its ack is a protocol violation; the arbiter still completes the access and pulses the ack.
- Reset mid-access: mem_req drops immediately and no ack is generated.

Test Plan:
- Fetch only: if_req=1, if_addr=16'h0004, mem_ready 1 cycle after mem_req, mem_rdata=16'h1234 -> mem_we=0, mem_addr=16'h0004, if_ack pulse 3 cycles after if_req, if_rdata=16'h1234, pipe_stall=1 for cycles 0..2 and 0 in the ack cycle.
- Simultaneous: if_req=1 (addr 16'h0010), dm_req=1, dm_we=1, dm_addr=16'h0100, dm_wdata=16'hBEEF -> store serviced first (mem_we=1, mem_wdata=16'hBEEF), dm_ack, one bubble, then fetch at 16'h0010, if_ack. No overlap of mem_req.
- Load with 4-cycle memory latency: dm_req, dm_we=0, dm_addr=16'h0200, mem_rdata=16'h00FF -> mem_addr stable 4 cycles, dm_rdata=16'h00FF, dm_ack single pulse.
- Timeout: TIMEOUT=15, mem_ready held 0 -> after 15 wait cycles err_timeout=1 and stays 1, mem_req=0, the requester's ack pulses with rdata=0. The next access completes normally and err_timeout remains 1.
- Timeout boundary: mem_ready asserted exactly in the 15th wait cycle -> normal completion, err_timeout=0.
- Reset mid-access: rst_n=0 during a DATA wait -> mem_req, acks, and pipe-related outputs clear asynchronously. After release, a held if_req is serviced from IDLE.
